// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO interlocks,
// taken-branch flush, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int REGW      = 5,
    parameter int MD_CYCLES = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_branch_taken,
    input  logic            id_md_start,
    input  logic            id_md_read,
    output logic            pc_write,
    output logic            ifid_hold,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic            md_busy,
    output logic [15:0]     stall_cycles
);

    localparam logic MD_IDLE = 1'b0;
    localparam logic MD_BUSY = 1'b1;

    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

    logic        r_state;
    logic [7:0]  r_md_cnt;
    logic [15:0] r_stall_cycles;

    logic w_rd_nz;
    logic w_load_hz;
    logic w_md_hz;
    logic w_stall;
    logic w_md_accept;

    assign w_rd_nz   = (ex_rd != '0);
    assign w_load_hz = ex_memread & w_rd_nz &
                       ((ex_rd == id_rs) |
                        (id_uses_rt & (ex_rd == id_rt)));
    assign w_md_hz   = md_busy & (id_md_read | id_md_start);
    assign w_stall   = (w_load_hz | w_md_hz) & ~ex_branch_taken;

    // A start only launches from idle and only if the ID slot advances.
    assign w_md_accept = (r_state == MD_IDLE) & id_md_start &
                         ~w_stall & ~ex_branch_taken;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= MD_IDLE;
            r_md_cnt <= 8'd0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (w_md_accept) begin
                        r_state  <= MD_BUSY;
                        r_md_cnt <= MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (r_md_cnt == 8'd0) begin
                        r_state <= MD_IDLE;
                    end else begin
                        r_md_cnt <= r_md_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state  <= MD_IDLE;
                    r_md_cnt <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cycles <= 16'd0;
        end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign md_busy      = (r_state == MD_BUSY);
    assign stall_cycles = r_stall_cycles;

    // Branch suppresses the stall term, so it wins on every output.
    assign pc_write    = ~w_stall;
    assign ifid_hold   = w_stall;
    assign ifid_flush  = ex_branch_taken;
    assign idex_bubble = w_stall | ex_branch_taken;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push
// expected responses, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        id_md_start;
    logic        id_md_read;
    logic        pc_write;
    logic        ifid_hold;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        md_busy;
    logic [15:0] stall_cycles;

    pipe_hazard_ctrl #(.REGW(5), .MD_CYCLES(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_memread     (ex_memread),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .id_md_start    (id_md_start),
        .id_md_read     (id_md_read),
        .pc_write       (pc_write),
        .ifid_hold      (ifid_hold),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .md_busy        (md_busy),
        .stall_cycles   (stall_cycles)
    );

    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {pc_write, ifid_hold, ifid_flush, idex_bubble, md_busy}
    localparam logic [4:0] RUN   = 5'b10000;
    localparam logic [4:0] STALL = 5'b01010;
    localparam logic [4:0] BR    = 5'b10110;
    localparam logic [4:0] MDSTL = 5'b01011;
    localparam logic [4:0] MDRUN = 5'b10001;
    localparam logic [4:0] MDBR  = 5'b10111;

    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e = exp_q.pop_front();
            act = {pc_write, ifid_hold, ifid_flush, idex_bubble, md_busy};
            checks++;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got %b want %b", e.name, act, e.ctrl);
            end
            checks++;
            if (stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL %s stall_cycles got %h want %h",
                         e.name, stall_cycles, e.sc);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic rst, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] rd,
                       input logic br, input logic mds,
                       input logic mdr);
        reset           = rst;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = urt;
        ex_memread      = mr;
        ex_rd           = rd;
        ex_branch_taken = br;
        id_md_start     = mds;
        id_md_read      = mdr;
    endtask

    task automatic push(input string n, input logic [4:0] c,
                        input logic [15:0] sc);
        exp_t e;
        e.name = n;
        e.ctrl = c;
        e.sc   = sc;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] rd,
                        input logic br, input logic mds,
                        input logic mdr, input string n,
                        input logic [4:0] c, input logic [15:0] sc);
        cyc();
        drv(rst, rs, rt, urt, mr, rd, br, mds, mdr);
        push(n, c, sc);
    endtask

    initial begin
        #800000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        //   rst rs     rt     urt   mr    rd     br    mds   mdr
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
             "rst_idle", RUN, 16'd0);
        step(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0,
             "rst_follow", STALL, 16'd0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
             "post_rst", RUN, 16'd0);
        step(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0,
             "load_rs", STALL, 16'd0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
             "sc_inc", RUN, 16'd1);
        step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0,
             "reg0", RUN, 16'd1);
        step(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0,
             "load_rt", STALL, 16'd1);
        step(1'b1, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0,
             "rt_unused", RUN, 16'd2);
        step(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0,
             "no_load", RUN, 16'd2);
        step(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0,
             "load_br", BR, 16'd2);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0,
             "md_br_drop", BR, 16'd2);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
             "md_dropped", RUN, 16'd2);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
             "md_start", RUN, 16'd2);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
             "md_c1", MDSTL, 16'd2);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
             "md_c2", MDSTL, 16'd3);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1,
             "md_c3_br", MDBR, 16'd4);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
             "md_c4", MDSTL, 16'd4);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
             "md_release", RUN, 16'd5);
        step(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0,
             "md_start_stalled", STALL, 16'd5);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
             "md_not_started", RUN, 16'd6);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
             "md_start2", RUN, 16'd6);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
             "md_busy2", MDRUN, 16'd6);
        cyc();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
             "md_aborted", RUN, 16'd0);
        for (int i = 0; i < 65540; i++) begin
            cyc();
            drv(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
            if (i == 0)     push("sat_start", STALL, 16'd0);
            if (i == 65534) push("sat_fffe", STALL, 16'hFFFE);
            if (i == 65535) push("sat_ffff", STALL, 16'hFFFF);
            if (i == 65539) push("sat_hold", STALL, 16'hFFFF);
        end
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
             "sat_after", RUN, 16'hFFFF);
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
